// File: rtl/shift_add_mult4.sv
// ---------------------------------------------------------------------------
// shift_add_mult4
//
// Sequential unsigned W x W -> 2W shift-and-add multiplier. A single W-bit
// ripple-carry adder is reused once per cycle to accumulate partial products,
// so one multiply takes W iterations instead of a full array multiplier.
//
// Handshake toward the controlling block (valid/ready semantics):
//   start is a request that is accepted only on a clock edge where the block
//   is in IDLE; a start seen in RUN or DONE is dropped, not queued. busy is
//   high for exactly the W cycles of iteration. done is a one-cycle pulse,
//   and product is valid from that cycle on. product is held until the next
//   accepted start completes.
//
// Ports:
//   clk      in   1    rising-edge clock
//   rst_n    in   1    asynchronous active-low reset (aborts any operation)
//   start    in   1    request, sampled only in IDLE
//   a        in   W    multiplicand, captured on accepted start
//   b        in   W    multiplier, captured on accepted start
//   product  out  2W   registered result a*b
//   busy     out  1    high while iterating
//   done     out  1    one-cycle completion pulse
//
// All outputs are registered; there is no combinational input-to-output path.
// W must be at least 2.
// ---------------------------------------------------------------------------
module shift_add_mult4 #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] product,
    output logic           busy,
    output logic           done
);

    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Private copies of the operands: m is the multiplicand, lo starts as the
    // multiplier and is consumed LSB-first while the low product bits shift
    // in from the top. hi holds the running upper half of the accumulator.
    logic [W-1:0]  m;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic [CW-1:0] cnt;

    // Ripple-carry adder: hi + (lo[0] ? m : 0), carry-in tied low.
    logic [W-1:0]  addend;
    logic [W-1:0]  sum;
    logic [W:0]    rc;

    // Accumulator after the right shift. The adder carry-out lands in the
    // MSB of hi, so the bit above hi after the shift is always zero and needs
    // no storage; nothing is ever dropped.
    logic [W-1:0]  hi_sh;
    logic [W-1:0]  lo_sh;
    logic          last_iter;

    assign addend = lo[0] ? m : '0;
    assign rc[0]  = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign sum[i]  = hi[i] ^ addend[i] ^ rc[i];
        assign rc[i+1] = (hi[i] & addend[i]) | (rc[i] & (hi[i] ^ addend[i]));
    end

    assign hi_sh     = {rc[W], sum[W-1:1]};
    assign lo_sh     = {sum[0], lo[W-1:1]};
    assign last_iter = (cnt == CW'(W - 1));

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)     state_next = RUN;
            RUN:     if (last_iter) state_next = DONE;
            DONE:                   state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath and registered outputs. busy/done are registered from the
    // next state so they line up with the state they describe.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m       <= '0;
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            busy <= (state_next == RUN);
            done <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        m   <= a;
                        hi  <= '0;
                        lo  <= b;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    hi  <= hi_sh;
                    lo  <= lo_sh;
                    cnt <= cnt + 1'b1;
                    if (last_iter) begin
                        product <= {hi_sh, lo_sh};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult4.sv
// ---------------------------------------------------------------------------
// tb_shift_add_mult4
//
// Bench for shift_add_mult4 (W=4). A timing model derived from the latency
// rules (accept at edge k -> busy after edges k..k+W-1, done after edge k+W,
// next accept no earlier than edge k+W+2) predicts busy/done/product every
// cycle; a queue of a*b values is popped on every done pulse. Directed cases
// additionally pin literal products.
// ---------------------------------------------------------------------------
module tb_shift_add_mult4;

    localparam int W = 4;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] product;
    logic           busy;
    logic           done;

    int checks = 0;
    int errors = 0;

    shift_add_mult4 #(.W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int             cyc = 0;
    int             k = 0;
    bit             have = 1'b0;
    logic [2*W-1:0] pend = '0;
    logic [2*W-1:0] prod_exp = '0;
    logic [2*W-1:0] exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have     = 1'b0;
            prod_exp = '0;
            exp_q.delete();
        end else begin
            cyc++;
            if (have && cyc == k + W) prod_exp = pend;
            if (start && (!have || cyc >= k + W + 2)) begin
                have = 1'b1;
                k    = cyc;
                pend = {4'b0, a} * {4'b0, b};
                exp_q.push_back(pend);
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", busy, (have && cyc >= k && cyc <= k + W - 1));
            chk("done", done, (have && cyc == k + W));
            chk("product", product, prod_exp);
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_done", 1'b1, 1'b0);
                end else begin
                    chk("sb_product", product, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("done_timeout", 1'b0, 1'b1);
    endtask

    task automatic pulse_start(input logic [W-1:0] ta, input logic [W-1:0] tb_v);
        @(posedge clk); #1;
        a = ta; b = tb_v; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic [2*W-1:0] lit, input string nm);
        bit ok;
        pulse_start(ta, tb_v);
        wait_done(ok);
        if (ok) chk(nm, product, lit);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        int ndone;
        int last_cyc;
        logic [W-1:0] cur_a, cur_b;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_product", product, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // T1
        do_op(4'd15, 4'd15, 8'hE1, "t1_15x15");
        // T2
        do_op(4'd0, 4'd9, 8'h00, "t2_0x9");
        do_op(4'd9, 4'd0, 8'h00, "t2_9x0");
        // T3
        do_op(4'd10, 4'd12, 8'h78, "t3_10x12");
        do_op(4'd1, 4'd9, 8'h09, "t3_1x9");
        do_op(4'd8, 4'd2, 8'h10, "t3_8x2");

        // T4: second request mid-RUN is lost
        pulse_start(4'd7, 4'd6);
        @(posedge clk); #1;
        a = 4'd3; b = 4'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(ok);
        if (ok) chk("t4_7x6", product, 8'd42);
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("t4_no_second_done", ndone, 0);
        chk("t4_product_held", product, 8'd42);

        // T5: reset in the second RUN cycle
        pulse_start(4'd13, 4'd11);
        @(posedge clk); #3;
        chk("t5_busy_before_rst", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_done", done, 1'b0);
        chk("t5_rst_product", product, 8'h00);
        ndone = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("t5_no_done_in_rst", ndone, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_op(4'd2, 4'd3, 8'd6, "t5_2x3");

        // T6: start held high, random operands per accept
        @(posedge clk); #1;
        cur_a = W'($urandom_range(0, 15));
        cur_b = W'($urandom_range(0, 15));
        a = cur_a; b = cur_b; start = 1'b1;
        last_cyc = 0;
        for (int n = 0; n < 12; n++) begin
            wait_done(ok);
            if (!ok) break;
            chk("t6_product", product, {4'b0, cur_a} * {4'b0, cur_b});
            if (n > 0) chk("t6_period", cyc - last_cyc, W + 2);
            last_cyc = cyc;
            cur_a = W'($urandom_range(0, 15));
            cur_b = W'($urandom_range(0, 15));
            a = cur_a; b = cur_b;
        end
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
